clint_timer_unit: RTL

Memory-mapped RISC-V timer/software-interrupt unit sitting directly upstream of the trap controller. It owns the 64-bit `mtime`/`mtimecmp` pair and the `msip` bit, and serves 32-bit load/store requests from the LSU/arbiter through a valid/ready request and response handshake. It drives the level-sensitive `mtip_o` and `msip_o` lines that the trap controller gates with `mie`/`mstatus` to raise machine timer and software interrupts.

---
 rtl/clint_pkg.sv | 15 +
 rtl/clint_tick_gen.sv | 23 ++
 rtl/clint_timer_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared register offsets and bus FSM encoding for the CLINT timer unit.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic {
        CLINT_BUS_IDLE = 1'b0,
        CLINT_BUS_RESP = 1'b1
    } clint_bus_state_e;

endpackage

// File: rtl/clint_tick_gen.sv
// mtime tick divider: counts 0..TICK_DIV-1 and pulses tick_o on the terminal count.
module clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam logic [15:0] TERM = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    // With TICK_DIV = 1 the counter sits at 0 == TERM, so tick_o is constantly 1.
    assign tick_o = (r_cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cnt <= '0;
        else if (tick_o) r_cnt <= '0;
        else             r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/clint_timer_unit.sv
// RISC-V CLINT: 64-bit mtime/mtimecmp, optional msip (CLINT_MSIP_EN), 32-bit valid/ready bus.
module clint_timer_unit
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mtip_o,
    output logic        msip_o
);

    clint_bus_state_e r_state, w_state_nxt;
    logic        w_tick, w_accept, w_wr, w_hit, w_err;
    logic        w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
    logic [15:0] w_off;
    logic [31:0] w_rdata, r_rdata, r_mtime_hi_shadow;
    logic [63:0] r_mtime, r_mtimecmp, w_mtime_nxt, w_mtimecmp_nxt;
    logic        r_err, r_mtip;

    clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (w_tick)
    );

    assign w_accept = (r_state == CLINT_BUS_IDLE) && req_valid_i;
    assign w_wr     = w_accept && req_write_i;
    assign w_off    = req_addr_i[15:0];
    assign w_hit    = (req_addr_i[31:16] == BASE_ADDR[31:16]) && (req_addr_i[1:0] == 2'b00);

`ifdef CLINT_MSIP_EN
    assign w_sel_msip = w_hit && (w_off == CLINT_MSIP_OFF);
`else
    assign w_sel_msip = 1'b0;
`endif
    assign w_sel_cmp_lo = w_hit && (w_off == CLINT_MTIMECMP_LO_OFF);
    assign w_sel_cmp_hi = w_hit && (w_off == CLINT_MTIMECMP_HI_OFF);
    assign w_sel_mt_lo  = w_hit && (w_off == CLINT_MTIME_LO_OFF);
    assign w_sel_mt_hi  = w_hit && (w_off == CLINT_MTIME_HI_OFF);
    assign w_err = !(w_sel_msip || w_sel_cmp_lo || w_sel_cmp_hi || w_sel_mt_lo || w_sel_mt_hi);

    // mtime hi reads come from the shadow captured by the preceding lo read.
    always_comb begin
        w_rdata = '0;
        if (w_sel_msip)   w_rdata = {31'b0, msip_o};
        if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
        if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
        if (w_sel_mt_lo)  w_rdata = r_mtime[31:0];
        if (w_sel_mt_hi)  w_rdata = r_mtime_hi_shadow;
    end

    // A half-word store replaces that half and swallows the tick: no carry, no increment.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr && w_sel_mt_lo)      w_mtime_nxt[31:0]  = req_wdata_i;
        else if (w_wr && w_sel_mt_hi) w_mtime_nxt[63:32] = req_wdata_i;
        else if (w_tick)              w_mtime_nxt        = r_mtime + 64'd1;
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr && w_sel_cmp_lo) w_mtimecmp_nxt[31:0]  = req_wdata_i;
        if (w_wr && w_sel_cmp_hi) w_mtimecmp_nxt[63:32] = req_wdata_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            CLINT_BUS_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) w_state_nxt = CLINT_BUS_RESP;
            end
            CLINT_BUS_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_state_nxt = CLINT_BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= CLINT_BUS_IDLE;
            r_mtime           <= '0;
            r_mtimecmp        <= '1;
            r_mtime_hi_shadow <= '0;
            r_mtip            <= 1'b0;
            r_rdata           <= '0;
            r_err             <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_mtip     <= (w_mtime_nxt >= w_mtimecmp_nxt);
            if (w_accept && !req_write_i && w_sel_mt_lo) r_mtime_hi_shadow <= r_mtime[63:32];
            if (w_accept) begin
                r_rdata <= req_write_i ? 32'd0 : w_rdata;
                r_err   <= w_err;
            end
        end
    end

`ifdef CLINT_MSIP_EN
    logic r_msip;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_msip <= 1'b0;
        else if (w_wr && w_sel_msip) r_msip <= req_wdata_i[0];
    end
    assign msip_o = r_msip;
`else
    assign msip_o = 1'b0;
`endif

    assign mtip_o      = r_mtip;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule
